// File: rtl/axis_block_averager_pkg.sv
// Shared definitions for the block averager slice.
//   NUM_CH            : number of averaged input channels
//   ACC_WIDTH_DEFAULT : default per-channel accumulator width
//   TICK_W            : tick counter width (longest block is 2^15 ticks)
//   out_state_t       : output sequencer states
package axis_block_averager_pkg;

  localparam int NUM_CH            = 6;
  localparam int ACC_WIDTH_DEFAULT = 48;
  localparam int TICK_W            = 15;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } out_state_t;

endpackage

// File: rtl/axis_block_averager_if.sv
// Stream bundle for the block averager.
//   S_AXIS_tdata[c] / S_AXIS_tvalid[c] : sample channel c+1 (channels 1..6), no tready
//   M_AXIS_tdata/tvalid/tready/tlast   : averaged word stream, tlast on channel-6 word
// Modports:
//   slave  : the averager (consumes samples, drives the output stream)
//   master : the environment (drives samples, sinks the output stream)
interface axis_block_averager_if
  import axis_block_averager_pkg::*;
#(
  parameter int DATA_WIDTH = 32
);

  logic [DATA_WIDTH-1:0] S_AXIS_tdata [NUM_CH];
  logic [NUM_CH-1:0]     S_AXIS_tvalid;

  logic [DATA_WIDTH-1:0] M_AXIS_tdata;
  logic                  M_AXIS_tvalid;
  logic                  M_AXIS_tready;
  logic                  M_AXIS_tlast;

  modport slave (
    input  S_AXIS_tdata, S_AXIS_tvalid, M_AXIS_tready,
    output M_AXIS_tdata, M_AXIS_tvalid, M_AXIS_tlast
  );

  modport master (
    output S_AXIS_tdata, S_AXIS_tvalid, M_AXIS_tready,
    input  M_AXIS_tdata, M_AXIS_tvalid, M_AXIS_tlast
  );

endinterface

// File: rtl/axis_block_averager_acc.sv
// Single-channel accumulator: sign-extends one sample and adds it on each
// accepted tick (0 when the channel is not valid).
//   a_clk, a_resetn : clock, asynchronous active-low reset
//   clear           : zero the accumulator (wins over add)
//   add             : accumulate this cycle
//   in_valid/in_data: channel sample
//   sum_next        : current sum plus this cycle's addend (value stored on add)
module axis_block_acc #(
  parameter int IN_W  = 32,
  parameter int ACC_W = 48
) (
  input  logic             a_clk,
  input  logic             a_resetn,
  input  logic             clear,
  input  logic             add,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  output logic [ACC_W-1:0] sum_next
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] addend;

  always_comb begin
    addend   = in_valid ? {{(ACC_W-IN_W){in_data[IN_W-1]}}, in_data} : '0;
    sum_next = acc + addend;
  end

  always_ff @(posedge a_clk or negedge a_resetn) begin
    if (!a_resetn)  acc <= '0;
    else if (clear) acc <= '0;
    else if (add)   acc <= sum_next;
  end

endmodule

// File: rtl/axis_block_averager.sv
// Six-channel block averager. Sums 2^avg_shift accepted ticks per channel,
// then streams the six floor-averaged words ch1..ch6 (tlast on ch6).
//   a_clk, a_resetn : clock, asynchronous active-low reset
//   axis            : sample inputs and output stream (slave modport)
//   sample_tick     : one-cycle sample strobe
//   enable          : 0 halts and clears accumulation
//   avg_shift       : log2 block length, latched at first tick of each block
//   overrun_count   : blocks dropped because the previous packet was busy (saturating)
//   block_count     : packets fully emitted (wrapping)
module axis_block_averager
  import axis_block_averager_pkg::*;
#(
  parameter int SAXIS_TDATA_WIDTH = 32,
  parameter int MAXIS_TDATA_WIDTH = 32,
  parameter int ACC_WIDTH         = ACC_WIDTH_DEFAULT
) (
  input  logic                  a_clk,
  input  logic                  a_resetn,
  axis_block_averager_if.slave  axis,
  input  logic                  sample_tick,
  input  logic                  enable,
  input  logic [3:0]            avg_shift,
  output logic [15:0]           overrun_count,
  output logic [31:0]           block_count
);

  localparam logic [2:0] LAST_IDX = 3'(NUM_CH - 1);

  function automatic logic [MAXIS_TDATA_WIDTH-1:0] scale(
    input logic [ACC_WIDTH-1:0] v,
    input logic [3:0]           sh
  );
    logic signed [ACC_WIDTH-1:0] t;
    t = $signed(v) >>> sh;
    return t[MAXIS_TDATA_WIDTH-1:0];
  endfunction

  logic                   accept;
  logic                   complete;
  logic                   acc_clear;
  logic [TICK_W-1:0]      tick_cnt;
  logic [3:0]             shift_lat;
  logic [3:0]             eff_shift;
  logic [TICK_W:0]        blk_len;
  logic [ACC_WIDTH-1:0]   sum_next [NUM_CH];
  logic [ACC_WIDTH-1:0]   hold     [NUM_CH];
  logic [3:0]             hold_shift;

  out_state_t             state;
  logic [2:0]             idx;
  logic [2:0]             nxt_idx;
  logic [MAXIS_TDATA_WIDTH-1:0] nxt_word;
  logic [MAXIS_TDATA_WIDTH-1:0] m_tdata;
  logic                   m_tvalid;
  logic                   m_tlast;
  logic                   hs;
  logic                   last_hs;
  logic                   load;

  assign axis.M_AXIS_tdata  = m_tdata;
  assign axis.M_AXIS_tvalid = m_tvalid;
  assign axis.M_AXIS_tlast  = m_tlast;

  // The first tick of a block already uses the new avg_shift, so a one-tick
  // block (shift 0) completes on the same tick that latches it.
  always_comb begin
    accept    = sample_tick & enable;
    eff_shift = (tick_cnt == '0) ? avg_shift : shift_lat;
    blk_len   = (TICK_W+1)'(1) << eff_shift;
    complete  = accept && ({1'b0, tick_cnt} == (blk_len - 1'b1));
    acc_clear = !enable || complete;
    hs        = m_tvalid & axis.M_AXIS_tready;
    last_hs   = hs && (idx == LAST_IDX);
    load      = complete && ((state == ST_IDLE) || last_hs);
    nxt_idx   = idx + 3'd1;
    nxt_word  = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (3'(c) == nxt_idx) nxt_word = scale(hold[c], hold_shift);
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    axis_block_acc #(
      .IN_W  (SAXIS_TDATA_WIDTH),
      .ACC_W (ACC_WIDTH)
    ) u_acc (
      .a_clk    (a_clk),
      .a_resetn (a_resetn),
      .clear    (acc_clear),
      .add      (accept),
      .in_valid (axis.S_AXIS_tvalid[c]),
      .in_data  (axis.S_AXIS_tdata[c]),
      .sum_next (sum_next[c])
    );
  end

  always_ff @(posedge a_clk or negedge a_resetn) begin
    if (!a_resetn) begin
      tick_cnt  <= '0;
      shift_lat <= '0;
    end else if (!enable) begin
      tick_cnt  <= '0;
    end else if (accept) begin
      if (tick_cnt == '0) shift_lat <= avg_shift;
      tick_cnt <= complete ? '0 : tick_cnt + 1'b1;
    end
  end

  // Output sequencer. A completion coinciding with the word-6 handshake
  // reloads directly, so the packet stream continues without an idle cycle.
  always_ff @(posedge a_clk or negedge a_resetn) begin
    if (!a_resetn) begin
      state         <= ST_IDLE;
      idx           <= '0;
      m_tdata       <= '0;
      m_tvalid      <= 1'b0;
      m_tlast       <= 1'b0;
      hold_shift    <= '0;
      overrun_count <= '0;
      block_count   <= '0;
      for (int unsigned c = 0; c < NUM_CH; c++) hold[c] <= '0;
    end else begin
      if (last_hs) block_count <= block_count + 1'b1;
      if (load) begin
        for (int unsigned c = 0; c < NUM_CH; c++) hold[c] <= sum_next[c];
        hold_shift <= eff_shift;
        state      <= ST_SEND;
        idx        <= '0;
        m_tdata    <= scale(sum_next[0], eff_shift);
        m_tvalid   <= 1'b1;
        m_tlast    <= 1'b0;
      end else begin
        if (complete && (overrun_count != '1)) overrun_count <= overrun_count + 1'b1;
        if (hs) begin
          if (idx == LAST_IDX) begin
            state    <= ST_IDLE;
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
          end else begin
            idx     <= nxt_idx;
            m_tdata <= nxt_word;
            m_tlast <= (nxt_idx == LAST_IDX);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_block_averager.sv
module tb_axis_block_averager;
  import axis_block_averager_pkg::*;

  localparam int W = 32;

  logic        a_clk = 1'b0;
  logic        a_resetn = 1'b0;
  logic        sample_tick = 1'b0;
  logic        enable = 1'b0;
  logic [3:0]  avg_shift = '0;
  logic [15:0] overrun_count;
  logic [31:0] block_count;

  logic [W-1:0] din [NUM_CH];
  logic [5:0]   vin = '1;
  logic         tready = 1'b1;

  axis_block_averager_if #(.DATA_WIDTH(W)) bus ();

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) bus.S_AXIS_tdata[c] = din[c];
    bus.S_AXIS_tvalid = vin;
    bus.M_AXIS_tready = tready;
  end

  axis_block_averager #(
    .SAXIS_TDATA_WIDTH (W),
    .MAXIS_TDATA_WIDTH (W),
    .ACC_WIDTH         (48)
  ) dut (
    .a_clk         (a_clk),
    .a_resetn      (a_resetn),
    .axis          (bus),
    .sample_tick   (sample_tick),
    .enable        (enable),
    .avg_shift     (avg_shift),
    .overrun_count (overrun_count),
    .block_count   (block_count)
  );

  always #5 a_clk = ~a_clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: per-channel running sums and a queue of pending output words.
  typedef struct { logic [31:0] d; bit last; } word_t;
  word_t  mq [$];
  word_t  cap [$];
  longint msum [NUM_CH];
  int     mn, mlen, mover;
  longint mblocks;

  task automatic model_reset();
    mq.delete();
    for (int c = 0; c < NUM_CH; c++) msum[c] = 0;
    mn = 0; mlen = 1; mover = 0; mblocks = 0;
  endtask

  function automatic longint floor_div(input longint s, input int n);
    longint q;
    q = s / n;
    if ((s % n) != 0 && s < 0) q = q - 1;
    return q;
  endfunction

  task automatic model_edge();
    bit hs, lhs;
    longint q;
    word_t w;
    if (!a_resetn) begin model_reset(); return; end
    hs  = (mq.size() > 0) && tready;
    lhs = hs && mq[0].last;
    if (hs) void'(mq.pop_front());
    if (lhs) mblocks++;
    if (!enable) begin
      for (int c = 0; c < NUM_CH; c++) msum[c] = 0;
      mn = 0;
    end else if (sample_tick) begin
      if (mn == 0) mlen = 1 << avg_shift;
      for (int c = 0; c < NUM_CH; c++)
        if (vin[c]) msum[c] += longint'($signed(din[c]));
      mn++;
      if (mn == mlen) begin
        if (mq.size() == 0) begin
          for (int c = 0; c < NUM_CH; c++) begin
            q = floor_div(msum[c], mlen);
            w.d = q[31:0];
            w.last = (c == NUM_CH - 1);
            mq.push_back(w);
          end
        end else if (mover < 65535) begin
          mover++;
        end
        for (int c = 0; c < NUM_CH; c++) msum[c] = 0;
        mn = 0;
      end
    end
  endtask

  task automatic check_cycle();
    chk("tvalid", 64'(bus.M_AXIS_tvalid), 64'(mq.size() > 0));
    if (mq.size() > 0) begin
      chk("tdata", 64'(bus.M_AXIS_tdata), 64'(mq[0].d));
      chk("tlast", 64'(bus.M_AXIS_tlast), 64'(mq[0].last));
    end else begin
      chk("tlast_idle", 64'(bus.M_AXIS_tlast), 64'd0);
    end
    chk("overrun_count", 64'(overrun_count), 64'(mover));
    chk("block_count", 64'(block_count), 64'(mblocks[31:0]));
  endtask

  task automatic step();
    word_t w;
    if (bus.M_AXIS_tvalid && tready) begin
      w.d = bus.M_AXIS_tdata; w.last = bus.M_AXIS_tlast;
      cap.push_back(w);
    end
    @(posedge a_clk);
    model_edge();
    #1;
    check_cycle();
  endtask

  task automatic do_reset();
    a_resetn = 1'b0;
    model_reset();
    #1;
    chk("rst_tvalid", 64'(bus.M_AXIS_tvalid), 64'd0);
    chk("rst_tdata", 64'(bus.M_AXIS_tdata), 64'd0);
    step(); step();
    a_resetn = 1'b1;
    cap.delete();
  endtask

  task automatic wait_words(input string name, input int n);
    for (int k = 0; k < 200 && cap.size() < n; k++) step();
    chk(name, 64'(cap.size()), 64'(n));
  endtask

  task automatic chk_packet(input string name, input logic [31:0] exp [NUM_CH]);
    wait_words({name, "_count"}, NUM_CH);
    if (cap.size() >= NUM_CH) begin
      for (int c = 0; c < NUM_CH; c++) begin
        chk($sformatf("%s_w%0d", name, c + 1), 64'(cap[c].d), 64'(exp[c]));
        chk($sformatf("%s_last%0d", name, c + 1), 64'(cap[c].last), 64'(c == NUM_CH - 1));
      end
    end
    cap.delete();
  endtask

  typedef struct {
    logic [3:0]  shift;
    logic [5:0]  vmask;
    logic [31:0] a   [NUM_CH];
    logic [31:0] b   [NUM_CH];
    logic [31:0] exp [NUM_CH];
  } vec_t;

  vec_t        vt [5];
  logic [31:0] e   [NUM_CH];
  logic [31:0] s1  [NUM_CH];
  int          exp_bc;

  initial begin
    vt[0].shift = 4'd2; vt[0].vmask = 6'b111111;
    vt[0].a = '{4, 8, -12, 0, 100, -1}; vt[0].b = '{4, 8, -12, 0, 100, -1};
    vt[0].exp = '{4, 8, -12, 0, 100, -1};
    vt[1].shift = 4'd1; vt[1].vmask = 6'b111111;
    vt[1].a = '{-5, 7, 5, -1, 32'h7FFF_FFFF, 32'h8000_0000};
    vt[1].b = '{-6, 0, 6, 0, 32'h7FFF_FFFF, 32'h8000_0000};
    vt[1].exp = '{-6, 3, 5, -1, 32'h7FFF_FFFF, 32'h8000_0000};
    vt[2].shift = 4'd2; vt[2].vmask = 6'b111101;
    vt[2].a = '{40, 40, 40, 40, 40, 40}; vt[2].b = '{40, 40, 40, 40, 40, 40};
    vt[2].exp = '{40, 0, 40, 40, 40, 40};
    vt[3].shift = 4'd0; vt[3].vmask = 6'b111111;
    vt[3].a = '{1, 2, 3, -4, -5, -6}; vt[3].b = '{1, 2, 3, -4, -5, -6};
    vt[3].exp = '{1, 2, 3, -4, -5, -6};
    vt[4].shift = 4'd3; vt[4].vmask = 6'b111111;
    vt[4].a = '{10, -10, 1, 0, -1, 3}; vt[4].b = '{-3, 3, 0, 1, 0, 4};
    vt[4].exp = '{3, -4, 0, 0, -1, 3};

    for (int c = 0; c < NUM_CH; c++) din[c] = '0;
    model_reset();
    do_reset();
    chk("rst_overrun", 64'(overrun_count), 64'd0);
    chk("rst_blocks", 64'(block_count), 64'd0);

    // Table: one block per vector, ticks every 3 cycles, tready high.
    enable = 1'b1; tready = 1'b1; exp_bc = 0;
    for (int v = 0; v < 5; v++) begin
      avg_shift = vt[v].shift; vin = vt[v].vmask;
      for (int t = 0; t < (1 << vt[v].shift); t++) begin
        for (int c = 0; c < NUM_CH; c++) din[c] = (t % 2 == 0) ? vt[v].a[c] : vt[v].b[c];
        sample_tick = 1'b1; step();
        sample_tick = 1'b0; step(); step();
      end
      chk_packet($sformatf("vec%0d", v), vt[v].exp);
      exp_bc++;
      chk($sformatf("vec%0d_blocks", v), 64'(block_count), 64'(exp_bc));
    end

    // Enable dropped after 2 ticks: only post-restore ticks are averaged.
    avg_shift = 4'd2; vin = 6'b111101;
    for (int c = 0; c < NUM_CH; c++) din[c] = 32'd100;
    for (int t = 0; t < 2; t++) begin sample_tick = 1'b1; step(); sample_tick = 1'b0; step(); end
    enable = 1'b0; step(); step(); step();
    enable = 1'b1;
    for (int c = 0; c < NUM_CH; c++) din[c] = 32'd8;
    for (int t = 0; t < 4; t++) begin sample_tick = 1'b1; step(); sample_tick = 1'b0; step(); end
    e = '{8, 0, 8, 8, 8, 8};
    chk_packet("enable_restore", e);
    vin = '1;

    // Single-tick blocks every cycle: 5 of every 6 completions overrun.
    do_reset();
    avg_shift = 4'd0; tready = 1'b1;
    din[0] = 32'h7FFF_FFFF; din[1] = 32'h8000_0000;
    for (int c = 2; c < NUM_CH; c++) din[c] = 32'(c);
    sample_tick = 1'b1;
    for (int t = 0; t < 60; t++) step();
    sample_tick = 1'b0;
    chk("overrun_after_60", 64'(overrun_count), 64'd50);
    for (int k = 0; k < 8; k++) step();

    // Backpressure across two completions: one overrun, first block held.
    do_reset();
    avg_shift = 4'd3; tready = 1'b0;
    s1 = '{11, 22, 33, 44, 55, 66};
    for (int c = 0; c < NUM_CH; c++) din[c] = s1[c];
    sample_tick = 1'b1;
    for (int t = 0; t < 8; t++) step();
    for (int c = 0; c < NUM_CH; c++) din[c] = 32'd1;
    for (int t = 0; t < 8; t++) step();
    sample_tick = 1'b0;
    step(); step();
    chk("bp_overrun", 64'(overrun_count), 64'd1);
    for (int k = 0; k < 4; k++) begin
      chk("bp_stable_tdata", 64'(bus.M_AXIS_tdata), 64'd11);
      chk("bp_stable_tvalid", 64'(bus.M_AXIS_tvalid), 64'd1);
      step();
    end
    tready = 1'b1;
    chk_packet("bp_first_block", s1);

    // Reset while word 3 is presented.
    do_reset();
    avg_shift = 4'd0; tready = 1'b1;
    for (int c = 0; c < NUM_CH; c++) din[c] = 32'(c + 1);
    sample_tick = 1'b1; step(); sample_tick = 1'b0;
    wait_words("pre_reset_words", 2);
    chk("word3_shown", 64'(bus.M_AXIS_tdata), 64'd3);
    #2;
    a_resetn = 1'b0;
    model_reset();
    #1;
    chk("midrst_tvalid", 64'(bus.M_AXIS_tvalid), 64'd0);
    chk("midrst_blocks", 64'(block_count), 64'd0);
    chk("midrst_overrun", 64'(overrun_count), 64'd0);
    step(); step();
    a_resetn = 1'b1;
    cap.delete();
    step();
    for (int c = 0; c < NUM_CH; c++) din[c] = 32'(c + 7);
    sample_tick = 1'b1; step(); sample_tick = 1'b0;
    e = '{7, 8, 9, 10, 11, 12};
    chk_packet("post_reset", e);

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      for (int c = 0; c < NUM_CH; c++) din[c] = $urandom;
      vin         = 6'($urandom);
      sample_tick = ($urandom_range(0, 1) == 1);
      tready      = ($urandom_range(0, 3) != 0);
      enable      = ($urandom_range(0, 49) != 0);
      if ($urandom_range(0, 19) == 0) avg_shift = 4'($urandom_range(0, 3));
      step();
    end
    sample_tick = 1'b0; tready = 1'b1;
    for (int k = 0; k < 10; k++) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
